// File: rtl/design_select_ctrl.sv
// Design select controller: sequences a safe hand-over of the shared pad mux
// between NUM_DESIGNS user designs. Pads are isolated, the select changes,
// and the newly selected design is held in reset before it is released.
module design_select_ctrl #(
  parameter int NUM_DESIGNS    = 4,
  parameter int QUIESCE_CYCLES = 8,
  parameter int RESET_CYCLES   = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   req_valid,
  input  logic [3:0]             req_id,
  output logic                   req_ready,
  output logic [3:0]             sel_id,
  output logic                   outputs_safe,
  output logic [NUM_DESIGNS-1:0] design_rst,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISOLATE = 2'd1,
    ST_SWITCH  = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  localparam logic [7:0] QUIESCE_LOAD  = 8'(QUIESCE_CYCLES);
  localparam logic [7:0] RESET_LOAD    = 8'(RESET_CYCLES);
  localparam logic [4:0] NUM_DESIGNS_W = 5'(NUM_DESIGNS);

  // FSM state, shared down-counter and latched target
  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_count;
  logic [7:0]       w_count_next;
  logic [3:0]       r_target;
  logic [3:0]       w_target_next;

  // Registered outputs and their next values
  logic [3:0]             r_sel_id;
  logic [3:0]             w_sel_next;
  logic                   r_safe;
  logic                   w_safe_next;
  logic [NUM_DESIGNS-1:0] r_design_rst;
  logic [NUM_DESIGNS-1:0] w_design_rst_next;
  logic [NUM_DESIGNS-1:0] w_sel_onehot;
  logic                   r_done;
  logic                   w_done_next;
  logic                   r_err;
  logic                   w_err_next;

  logic w_accept;
  logic w_legal;

  // Requests are only taken while idle; req_id matters only at that edge.
  assign w_accept = req_valid && (r_state == ST_IDLE);
  assign w_legal  = ({1'b0, req_id} < NUM_DESIGNS_W);

  // One-hot decode of the select that will be registered this edge
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DESIGNS; gi++) begin : g_onehot
      assign w_sel_onehot[gi] = (w_sel_next == 4'(gi));
    end
  endgenerate

  // State register: reset parks the FSM in HOLD so design 0 boots cleanly
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state  <= ST_HOLD;
      r_count  <= RESET_LOAD;
      r_target <= 4'd0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_target <= w_target_next;
    end
  end

  // Next-state logic: counter reaching 1 ends the ISOLATE/HOLD phase
  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_target_next = r_target;
    w_sel_next    = r_sel_id;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_legal) begin
          w_state_next  = ST_ISOLATE;
          w_count_next  = QUIESCE_LOAD;
          w_target_next = req_id;
        end
      end
      ST_ISOLATE: begin
        if (r_count <= 8'd1) begin
          w_state_next = ST_SWITCH;
        end else begin
          w_count_next = r_count - 8'd1;
        end
      end
      ST_SWITCH: begin
        // The only point where the pad mux select moves
        w_state_next = ST_HOLD;
        w_count_next = RESET_LOAD;
        w_sel_next   = r_target;
      end
      ST_HOLD: begin
        if (r_count <= 8'd1) begin
          w_state_next = ST_IDLE;
        end else begin
          w_count_next = r_count - 8'd1;
        end
      end
      default: begin
        w_state_next = ST_HOLD;
        w_count_next = RESET_LOAD;
      end
    endcase
  end

  // Output decode from the upcoming state so every output can be registered
  always_comb begin
    w_safe_next       = (w_state_next != ST_IDLE);
    w_done_next       = (r_state == ST_HOLD) && (w_state_next == ST_IDLE);
    w_err_next        = w_accept && !w_legal;
    w_design_rst_next = {NUM_DESIGNS{1'b1}};
    if (w_state_next == ST_IDLE) begin
      w_design_rst_next = ~w_sel_onehot;
    end
  end

  // Output registers: no combinational path from req_* to the pad controls
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_sel_id     <= 4'd0;
      r_safe       <= 1'b1;
      r_design_rst <= {NUM_DESIGNS{1'b1}};
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_sel_id     <= w_sel_next;
      r_safe       <= w_safe_next;
      r_design_rst <= w_design_rst_next;
      r_done       <= w_done_next;
      r_err        <= w_err_next;
    end
  end

  assign sel_id       = r_sel_id;
  assign outputs_safe = r_safe;
  assign design_rst   = r_design_rst;
  assign done         = r_done;
  assign err          = r_err;
  assign req_ready    = (r_state == ST_IDLE);
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_design_select_ctrl.sv
// Testbench for design_select_ctrl: timestamp-based reference model with an
// event scoreboard (done/err) plus per-cycle checks of the pad controls.
module tb_design_select_ctrl;

  localparam int ND = 4;
  localparam int Q  = 8;
  localparam int R  = 16;
  localparam int NEVER = 1 << 30;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [3:0]    req_id = 4'd0;
  logic          req_ready;
  logic [3:0]    sel_id;
  logic          outputs_safe;
  logic [ND-1:0] design_rst;
  logic          busy;
  logic          done;
  logic          err;

  design_select_ctrl #(
    .NUM_DESIGNS   (ND),
    .QUIESCE_CYCLES(Q),
    .RESET_CYCLES  (R)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .req_valid   (req_valid),
    .req_id      (req_id),
    .req_ready   (req_ready),
    .sel_id      (sel_id),
    .outputs_safe(outputs_safe),
    .design_rst  (design_rst),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    int         due;
    logic [3:0] sel;
  } evt_t;

  evt_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: a sequence is described by when it was accepted, when
  // the select flips and when the controller is idle again.
  bit         m_in_reset = 1'b1;
  int         m_busy_end = NEVER;
  int         m_switch   = 0;
  logic [3:0] m_prev     = 4'd0;
  logic [3:0] m_target   = 4'd0;

  function automatic logic [3:0] model_sel(input int c);
    return (c >= m_switch) ? m_target : m_prev;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Applied on every rising edge with the inputs the DUT just sampled
  task automatic model_update();
    cyc++;
    if (!rst && req_valid && (cyc - 1) >= m_busy_end) begin
      if (int'(req_id) < ND) begin
        m_prev     = m_target;
        m_target   = req_id;
        m_switch   = cyc + Q + 1;
        m_busy_end = cyc + Q + 1 + R;
        exp_q.push_back('{is_err: 1'b0, due: m_busy_end, sel: req_id});
      end else begin
        exp_q.push_back('{is_err: 1'b1, due: cyc, sel: model_sel(cyc)});
      end
    end
  endtask

  task automatic step(input bit v, input logic [3:0] id);
    req_valid = v;
    req_id    = id;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic reset_assert();
    rst        = 1'b1;
    m_in_reset = 1'b1;
    m_busy_end = NEVER;
    exp_q.delete();
    #1;
  endtask

  task automatic reset_release();
    rst        = 1'b0;
    m_in_reset = 1'b0;
    m_prev     = 4'd0;
    m_target   = 4'd0;
    m_switch   = 0;
    m_busy_end = cyc + R;
    exp_q.push_back('{is_err: 1'b0, due: cyc + R, sel: 4'd0});
  endtask

  // Monitor: samples on the falling edge, compares against the model
  always @(negedge clk) begin
    int            b;
    logic [3:0]    s;
    logic [ND-1:0] exp_rst;
    evt_t          e;
    if (m_in_reset) begin
      chk("rst_sel_id", int'(sel_id), 0);
      chk("rst_outputs_safe", int'(outputs_safe), 1);
      chk("rst_design_rst", int'(design_rst), (1 << ND) - 1);
      chk("rst_busy", int'(busy), 1);
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
    end else begin
      b = (cyc < m_busy_end) ? 1 : 0;
      s = model_sel(cyc);
      exp_rst = {ND{1'b1}};
      if (b == 0) begin
        exp_rst[s[1:0]] = 1'b0;
      end
      chk("busy", int'(busy), b);
      chk("req_ready", int'(req_ready), 1 - b);
      chk("outputs_safe", int'(outputs_safe), b);
      chk("sel_id", int'(sel_id), int'(s));
      chk("design_rst", int'(design_rst), int'(exp_rst));
      if (done || err) begin
        chk("evt_exclusive", int'(done & err), 0);
        if (exp_q.size() == 0) begin
          chk("evt_unexpected", int'({done, err}), 0);
        end else begin
          e = exp_q.pop_front();
          chk("evt_kind_err", int'(err), int'(e.is_err));
          chk("evt_cycle", cyc, e.due);
          chk("evt_sel", int'(sel_id), int'(e.sel));
        end
      end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        chk("evt_missing_at_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    bit         v;
    logic [3:0] id;

    // Held in reset, then boot of design 0
    repeat (3) step(1'b0, 4'd0);
    reset_release();
    repeat (R + 3) step(1'b0, 4'd0);

    // Request the already selected design 0
    step(1'b1, 4'd0);
    repeat (Q + R + 3) step(1'b0, 4'd0);

    // Switch 0 -> 2
    step(1'b1, 4'd2);
    repeat (Q + R + 3) step(1'b0, 4'd0);

    // Illegal id
    step(1'b1, 4'd7);
    repeat (3) step(1'b0, 4'd0);

    // Request 1, then hold a request for 3 through the whole sequence
    step(1'b1, 4'd1);
    repeat (Q + 1 + R + 2) step(1'b1, 4'd3);
    repeat (Q + R + 3) step(1'b0, 4'd0);

    // Randomized traffic, mostly legal ids
    repeat (400) begin
      v  = ($urandom_range(0, 2) == 0);
      id = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      step(v, id);
    end
    repeat (Q + R + 3) step(1'b0, 4'd0);

    // Reset during cycle 5 of ISOLATE
    step(1'b1, 4'd1);
    repeat (4) step(1'b0, 4'd0);
    reset_assert();
    chk("async_sel_id", int'(sel_id), 0);
    chk("async_design_rst", int'(design_rst), (1 << ND) - 1);
    chk("async_outputs_safe", int'(outputs_safe), 1);
    chk("async_busy", int'(busy), 1);
    chk("async_req_ready", int'(req_ready), 0);
    repeat (3) step(1'b0, 4'd0);
    reset_release();
    repeat (R + 3) step(1'b0, 4'd0);
    step(1'b1, 4'd1);
    repeat (Q + R + 3) step(1'b0, 4'd0);

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
